rr_byte_arbiter: RTL



---
 rtl/rr_byte_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/rr_byte_arbiter.sv
// Round-robin arbiter sharing one registered byte channel among NUM_REQ requesters.
// Each grant lasts until the requester's last beat or MAX_BURST beats, whichever comes first.
module rr_byte_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [DATA_W-1:0]          req_data [0:NUM_REQ-1],
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_last,
  input  logic                       out_ready
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [SRC_W-1:0] ptr_reg;
  logic [SRC_W-1:0] grant_reg;
  logic [CNT_W-1:0] beat_cnt_reg;

  logic             slot_free;
  logic             accept;
  logic             final_beat;
  logic [SRC_W-1:0] arb_idx;
  logic             arb_hit;

  assign slot_free  = !out_valid || out_ready;
  assign accept     = (state == XFER) && req_valid[grant_reg] && slot_free;
  assign final_beat = req_last[grant_reg] || (beat_cnt_reg == CNT_W'(MAX_BURST - 1));

  // Scan starts just past the last-served requester, so it gets lowest priority.
  always_comb begin
    logic [SRC_W-1:0] idx;
    arb_idx = '0;
    arb_hit = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!arb_hit && req_valid[idx]) begin
        arb_hit = 1'b1;
        arb_idx = idx;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (state == XFER) && (grant_reg == SRC_W'(gi)) && slot_free;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr_reg      <= SRC_W'(NUM_REQ - 1);
      grant_reg    <= '0;
      beat_cnt_reg <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_src      <= '0;
      out_last     <= 1'b0;
    end else begin
      // A pop and an accept in the same cycle keep out_valid high with fresh data.
      if (accept) begin
        out_valid    <= 1'b1;
        out_data     <= req_data[grant_reg];
        out_src      <= grant_reg;
        out_last     <= final_beat;
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant_reg    <= arb_idx;
            beat_cnt_reg <= '0;
            state        <= XFER;
          end
        end
        XFER: begin
          if (accept && final_beat) begin
            ptr_reg <= grant_reg;
            state   <= IDLE;
          end
        end
        default: state <= state_t'('x);
      endcase
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_ready_idle: assert property (@(posedge clk) disable iff (reset)
    (state == IDLE) |-> (req_ready == '0));
  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> $stable({out_valid, out_data, out_src, out_last}));

endmodule
